// File: rtl/video_pack_fifo.sv
// rtl/video_pack_fifo.sv - narrow-to-wide packing FIFO with flush/keep; VIDEO_PACK_FIFO_FWFT_EN selects FWFT read
// Default build: one-cycle registered read latency.
module video_pack_fifo #(
  parameter int IN_WIDTH         = 32,
  parameter int RATIO            = 8,
  parameter int DEPTH_WIDTH      = 8,
  parameter int ALMOST_FULL_NUM  = 2**DEPTH_WIDTH - 4,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IN_WIDTH-1:0]           wr_data,
  input  logic                          wr_en,
  input  logic                          wr_last,
  output logic                          wr_full,
  output logic                          almost_full,
  output logic [IN_WIDTH*RATIO-1:0]     rd_data,
  output logic [RATIO-1:0]              rd_keep,
  input  logic                          rd_en,
  output logic                          rd_empty,
  output logic                          almost_empty,
  output logic [DEPTH_WIDTH:0]          rd_water_level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int DEPTH     = 2**DEPTH_WIDTH;
  localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [DEPTH_WIDTH:0] AF_LVL = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_LVL = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [LANE_W-1:0]    lane_cnt;
  logic [OUT_WIDTH-1:0] acc_data;
  logic [RATIO-1:0]     acc_keep;
  logic [OUT_WIDTH-1:0] pack_data;
  logic [RATIO-1:0]     pack_keep;

  logic [DEPTH_WIDTH:0] wptr, rptr, wptr_n, rptr_n, mem_cnt_n, level_n;
  logic                 wr_acc, rd_acc, commit, mem_rd, rd_empty_n;

  logic [OUT_WIDTH-1:0] mem_data [DEPTH];
  logic [RATIO-1:0]     mem_keep [DEPTH];

  assign wr_acc = wr_en & ~wr_full;
  assign commit = wr_acc & ((lane_cnt == LANE_W'(RATIO-1)) | wr_last);

  // Current write merged into the accumulator; this is what a commit stores.
  always_comb begin
    pack_data = acc_data;
    pack_keep = acc_keep;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_cnt == LANE_W'(i)) begin
        pack_data[i*IN_WIDTH +: IN_WIDTH] = wr_data;
        pack_keep[i]                      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end else if (wr_acc) begin
      if (commit) begin
        lane_cnt <= '0;
        acc_data <= '0;
        acc_keep <= '0;
      end else begin
        lane_cnt <= lane_cnt + LANE_W'(1);
        acc_data <= pack_data;
        acc_keep <= pack_keep;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem_data[wptr[DEPTH_WIDTH-1:0]] <= pack_data;
      mem_keep[wptr[DEPTH_WIDTH-1:0]] <= pack_keep;
    end
  end

`ifdef VIDEO_PACK_FIFO_FWFT_EN
  logic out_valid, out_valid_n, mem_has_word;

  assign mem_has_word = (wptr != rptr);
  assign rd_acc       = rd_en & out_valid;
  // Refill the output stage whenever it is empty or being popped this cycle.
  assign mem_rd       = (~out_valid | rd_acc) & mem_has_word;
  assign out_valid_n  = mem_rd | (out_valid & ~rd_acc);
  assign rd_empty_n   = ~out_valid_n;
  assign level_n      = mem_cnt_n + {{DEPTH_WIDTH{1'b0}}, out_valid_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rd_data   <= '0;
      rd_keep   <= '0;
    end else begin
      out_valid <= out_valid_n;
      if (mem_rd) begin
        rd_data <= mem_data[rptr[DEPTH_WIDTH-1:0]];
        rd_keep <= mem_keep[rptr[DEPTH_WIDTH-1:0]];
      end
    end
  end
`else
  assign rd_acc     = rd_en & ~rd_empty;
  assign mem_rd     = rd_acc;
  assign rd_empty_n = (mem_cnt_n == '0);
  assign level_n    = mem_cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_keep <= '0;
    end else if (rd_acc) begin
      rd_data <= mem_data[rptr[DEPTH_WIDTH-1:0]];
      rd_keep <= mem_keep[rptr[DEPTH_WIDTH-1:0]];
    end
  end
`endif

  assign wptr_n    = wptr + {{DEPTH_WIDTH{1'b0}}, commit};
  assign rptr_n    = rptr + {{DEPTH_WIDTH{1'b0}}, mem_rd};
  assign mem_cnt_n = wptr_n - rptr_n;

  // Count can never exceed DEPTH, so its MSB alone marks full storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr           <= '0;
      rptr           <= '0;
      wr_full        <= 1'b0;
      almost_full    <= 1'b0;
      rd_empty       <= 1'b1;
      almost_empty   <= 1'b1;
      rd_water_level <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      wptr           <= wptr_n;
      rptr           <= rptr_n;
      wr_full        <= mem_cnt_n[DEPTH_WIDTH];
      almost_full    <= (level_n >= AF_LVL);
      rd_empty       <= rd_empty_n;
      almost_empty   <= (level_n <= AE_LVL);
      rd_water_level <= level_n;
      if (wr_en & wr_full)
        overflow <= 1'b1;
      if (rd_en & rd_empty)
        underflow <= 1'b1;
    end
  end

endmodule

// File: doc/video_pack_fifo.md
# video_pack_fifo

Single-clock, parametrised width-packing FIFO for the video datapath: it accepts narrow pixel words and packs `RATIO` of them into one wide word for the AXI/DDR burst side. Compared with the fixed 32→256 asynchronous FIFO it generalises lane count and depth, and adds three behaviours:
- partial-word flush at line/frame end, with a per-lane keep mask;
- sticky overflow/underflow error flags;
- an optional first-word-fall-through read port.

## Interface
- `IN_WIDTH`, 32, width of one write lane (bits)
- `RATIO`, 8, lanes per wide word; power of two, 1..16; `OUT_WIDTH = IN_WIDTH*RATIO`
- `DEPTH_WIDTH`, 8, wide-word storage = 2**DEPTH_WIDTH entries
- `ALMOST_FULL_NUM`, 2**DEPTH_WIDTH-4, almost_full threshold (wide words)
- `ALMOST_EMPTY_NUM`, 4, almost_empty threshold (wide words)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_data`  in  IN_WIDTH  narrow write word
- `wr_en`  in  1  write strobe
- `wr_last`  in  1  qualified by wr_en; commits the current partial word
- `wr_full`  out  1  storage holds 2**DEPTH_WIDTH wide words
- `almost_full`  out  1  level >= ALMOST_FULL_NUM
- `rd_data`  out  OUT_WIDTH  wide read word; lane 0 at LSBs
- `rd_keep`  out  RATIO  lane-valid mask for rd_data
- `rd_en`  in  1  read strobe
- `rd_empty`  out  1  no readable wide word
- `almost_empty`  out  1  level <= ALMOST_EMPTY_NUM
- `rd_water_level`  out  DEPTH_WIDTH+1  wide words committed and not yet read
- `overflow`  out  1  sticky: write attempted while wr_full
- `underflow`  out  1  sticky: read attempted while rd_empty

## Operation
- **Packer:**
  - Holds the lane accumulator, a lane counter `lane_cnt` (0..RATIO-1) and a keep accumulator.
  - An accepted write (`wr_en & !wr_full`) places `wr_data` in lane `lane_cnt` and sets `keep[lane_cnt]`.
- **Commit:**
  - Occurs on an accepted write when `lane_cnt == RATIO-1` or `wr_last == 1`.
  - Stores {word, keep} to memory at `wptr` and resets `lane_cnt` to 0.
  - Lanes not written in a partial word read back as zero.
- **Rejected writes:**
  - `wr_en` while `wr_full` is ignored entirely: packer unchanged and `overflow` is set.
  - The packer may hold up to RATIO-1 pending lanes while `wr_full` is high; they are not lost.
- **Reads:**
  - An accepted read (`rd_en & !rd_empty`) advances `rptr`.
  - `rd_en` while `rd_empty` is ignored and sets `underflow`.
- **Pointers:**
  - `wptr` and `rptr` are DEPTH_WIDTH+1 bits; full/empty are decided on the MSB difference.
  - Wrap-around is natural binary.
- **Level:** `rd_water_level` = committed − read; commit and read in the same cycle leave it unchanged.
- **Simultaneous events:** at full, a write with commit in the same cycle as a read is still rejected (`wr_full` is evaluated before the read takes effect). At empty, a read is rejected even when a commit occurs in the same cycle.
- **Error flags:** `overflow` and `underflow` clear only on reset.
- **Reset:** asserting `rst_n` low mid-operation immediately clears the pointers, packer, level and flags. Pending partial lanes are discarded.

## Timing
- **Reset values:**
  - `wr_full`, `almost_full`, `overflow`, `underflow` = 0
  - `rd_empty` = 1, `almost_empty` = 1
  - `rd_water_level` = 0, `rd_data` = 0, `rd_keep` = 0
- **Flags and level:** all are registered and reflect the state after the current edge's commit and read.
- **Write to readable:** a commit at edge N drops `rd_empty` after edge N.
- **Read latency (default):**
  - `rd_data` and `rd_keep` are valid in the cycle after the edge that accepted `rd_en`.
  - They hold that value until the next accepted read.
- Back-to-back reads at one word per cycle are supported; writes are sustained at one lane per cycle.

## Configuration
- Macro `VIDEO_PACK_FIFO_FWFT_EN`.
- **Defined** (first-word-fall-through):
  - An output-stage register prefetches the head word, so `rd_data`/`rd_keep` show the head word whenever `rd_empty == 0`.
  - `rd_en` pops that word.
  - `rd_empty` drops 2 edges after a commit into empty storage.
  - `rd_water_level` includes the prefetched word.
- **Undefined:** the one-cycle registered read latency described under Timing applies.

## Test plan
Bench configuration for all scenarios: IN_WIDTH=32, RATIO=8, DEPTH_WIDTH=4.

1. **Full-word pack.** Write 0x1..0x8 on 8 consecutive cycles, then read once.
   - `rd_data` = {0x8,0x7,…,0x1} (lane 0 = 0x1), `rd_keep` = 0xFF.
   - `rd_water_level` goes 1 → 0.
2. **Partial flush.** Write 0xA, 0xB, 0xC with `wr_last` on 0xC, then read.
   - `rd_keep` = 0x07, lanes 0..2 = 0xA/0xB/0xC, upper 160 bits zero.
3. **Fill and overflow.** Issue 128 writes.
   - After the 128th: `wr_full` = 1, level = 16, `almost_full` = 1 from level 12.
   - 129th write: ignored, `overflow` = 1.
   - Reading all 16 words returns the data in order.
4. **Underflow and simultaneous access.**
   - `rd_en` on empty: `underflow` = 1, level stays 0.
   - At level 5, a commit plus read in one cycle: level stays 5.
5. **Reset mid-operation.** With 3 lanes pending and level 7, pulse `rst_n` low.
   - All outputs return to their reset values.
   - 8 new writes then produce a word with `rd_keep` = 0xFF containing only the new data.
6. **FWFT build** (`VIDEO_PACK_FIFO_FWFT_EN` defined). Write 8 lanes.
   - `rd_empty` falls 2 edges after the commit, and `rd_data` is valid with `rd_en` low.
   - A single `rd_en` pop returns `rd_empty` = 1.
